// File: rtl/bash_out_arbiter_if.sv
// Requester / video-memory handshake bundle for the bash output arbiter.
// The master modport is the arbiter side and the slave modport is the requester/video-memory side.
interface bash_out_arbiter_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]   req_ready;
    logic [8*NREQ-1:0] req_char;
    logic [NREQ-1:0]   req_next;
    logic [NREQ-1:0]   req_done;
    logic              req_trunc;
    logic [NREQ-1:0]   grant;
    logic              in_newASCII_ready;
    logic [7:0]        lineIn;
    logic              lineIn_nextASCII;
    logic              in_solved;
    logic              out_solved;
    logic              out_newASCII_ready;

    modport master (
        input  req_ready, req_char, lineIn_nextASCII, out_solved, out_newASCII_ready,
        output req_next, req_done, req_trunc, grant, in_newASCII_ready, lineIn, in_solved
    );

    modport slave (
        output req_ready, req_char, lineIn_nextASCII, out_solved, out_newASCII_ready,
        input  req_next, req_done, req_trunc, grant, in_newASCII_ready, lineIn, in_solved
    );
endinterface

// File: rtl/bash_out_arbiter.sv
// Shares the bash screen-output channel among NREQ string requesters, one 00-terminated string per grant.
// Define BASH_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins); round-robin otherwise.
module bash_out_arbiter #(
    parameter int NREQ    = 4,
    parameter int MAX_LEN = 32
) (
    input  logic                clk,
    input  logic                rst,
    bash_out_arbiter_if.master  bus
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(MAX_LEN + 1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_STREAM   = 2'd1,
        ST_WAIT_ACK = 2'd2,
        ST_DONE     = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [CW-1:0]   count_q, count_d;
    logic            newrdy_q, newrdy_d;
    logic            solved_q, solved_d;
    logic            trunc_q, trunc_d;
    logic [NREQ-1:0] done_q, done_d;
    logic            rtrunc_q, rtrunc_d;

    logic [IW-1:0]   ptr_s;
    logic [IW:0]     pick_s;
    logic [7:0]      char_s;
    logic [7:0]      line_s;
    logic            at_max_s;
    logic            owner_ready_s;
    logic            end_s;
    logic            adv_s;

    // Walks downward so the requester closest to start (upward, wrapping) is the last and winning hit.
    function automatic logic [IW:0] pick_next(input logic [NREQ-1:0] req, input logic [IW-1:0] start);
        logic [IW:0] res;
        int          k;
        res = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            k = (int'(start) + i) % NREQ;
            if (req[IW'(k)]) begin
                res = {1'b1, IW'(k)};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

`ifdef BASH_ARB_FIXED_PRIO_EN
    assign ptr_s = '0;
`else
    logic [IW-1:0] ptr_q;

    // Round-robin pointer moves past the owner once its string is retired.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else if (state_q == ST_DONE) begin
            ptr_q <= (idx_q == IW'(NREQ - 1)) ? '0 : idx_q + IW'(1);
        end else begin
            ptr_q <= ptr_q;
        end
    end

    assign ptr_s = ptr_q;
`endif

    assign pick_s = pick_next(bus.req_ready, ptr_s);

    // Character mux from the one-hot owner.
    always_comb begin
        char_s = 8'h00;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_q[i]) begin
                char_s = char_s | bus.req_char[8*i +: 8];
            end else begin
                char_s = char_s;
            end
        end
    end

    assign at_max_s      = (count_q == CW'(MAX_LEN));
    assign owner_ready_s = |(bus.req_ready & grant_q);
    assign line_s        = ((state_q == ST_STREAM) && !at_max_s && owner_ready_s) ? char_s : 8'h00;
    assign end_s         = (state_q == ST_STREAM) && (line_s == 8'h00);
    // A consume pulse coinciding with the terminator is dropped: nothing left to advance.
    assign adv_s         = (state_q == ST_STREAM) && !end_s && bus.lineIn_nextASCII;

    // Next-state and registered-output decode.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        idx_d    = idx_q;
        count_d  = count_q;
        newrdy_d = newrdy_q;
        solved_d = solved_q;
        trunc_d  = trunc_q;
        done_d   = '0;
        rtrunc_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!bus.out_newASCII_ready && pick_s[IW]) begin
                    grant_d  = NREQ'(1) << pick_s[IW-1:0];
                    idx_d    = pick_s[IW-1:0];
                    count_d  = '0;
                    newrdy_d = 1'b1;
                    state_d  = ST_STREAM;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_STREAM: begin
                if (end_s) begin
                    newrdy_d = 1'b0;
                    solved_d = 1'b1;
                    trunc_d  = at_max_s || !owner_ready_s;
                    state_d  = ST_WAIT_ACK;
                end else if (adv_s) begin
                    count_d  = count_q + CW'(1);
                end else begin
                    count_d  = count_q;
                end
            end
            ST_WAIT_ACK: begin
                if (bus.out_solved) begin
                    solved_d = 1'b0;
                    done_d   = grant_q;
                    rtrunc_d = trunc_q;
                    state_d  = ST_DONE;
                end else begin
                    solved_d = 1'b1;
                end
            end
            ST_DONE: begin
                grant_d = '0;
                state_d = ST_IDLE;
            end
            default: begin
                grant_d  = '0;
                newrdy_d = 1'b0;
                solved_d = 1'b0;
                state_d  = ST_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            idx_q    <= '0;
            count_q  <= '0;
            newrdy_q <= 1'b0;
            solved_q <= 1'b0;
            trunc_q  <= 1'b0;
            done_q   <= '0;
            rtrunc_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            idx_q    <= idx_d;
            count_q  <= count_d;
            newrdy_q <= newrdy_d;
            solved_q <= solved_d;
            trunc_q  <= trunc_d;
            done_q   <= done_d;
            rtrunc_q <= rtrunc_d;
        end
    end

    assign bus.grant             = grant_q;
    assign bus.in_newASCII_ready = newrdy_q;
    assign bus.in_solved         = solved_q;
    assign bus.req_done          = done_q;
    assign bus.req_trunc         = rtrunc_q;
    assign bus.lineIn            = line_s;
    assign bus.req_next          = grant_q & {NREQ{adv_s}};
endmodule
